// File: rtl/bcd_clk_pkg.sv
// Shared types and constants for the BCD time-of-day sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_clk_pkg;

  // Sequencer states: one state per field step, plus the adjust step.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEC  = 3'd1,
    ST_MIN  = 3'd2,
    ST_HOUR = 3'd3,
    ST_ADJ  = 3'd4
  } state_t;

  // adj_sel encodings.
  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Packed-BCD limits shared by the seconds and minutes fields.
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_00 = 8'h00;

  // An adjust is real only with exactly one direction and a field selected.
  function automatic logic adj_req_valid(input logic inc, input logic dec,
                                         input logic [1:0] sel);
    return (inc ^ dec) && (sel != SEL_NONE);
  endfunction

endpackage

// File: rtl/bcd_field_limit.sv
// Applies a field's wrap limit to the shared +1 / -1 BCD results.
// Latency: combinational.
// Backpressure: none.
module bcd_field_limit
  import bcd_clk_pkg::*;
(
  input  logic [7:0] i_operand,
  input  logic [7:0] i_inc_res,
  input  logic [7:0] i_dec_res,
  input  logic [7:0] i_limit,
  input  logic       i_dec,
  output logic [7:0] o_result,
  output logic       o_wrap
);

  // Increment wraps limit->00, decrement wraps 00->limit; o_wrap flags either.
  always_comb begin
    o_wrap   = 1'b0;
    o_result = i_dec ? i_dec_res : i_inc_res;
    if (i_dec) begin
      if (i_operand == BCD_00) begin
        o_result = i_limit;
        o_wrap   = 1'b1;
      end
    end else begin
      if (i_operand == i_limit) begin
        o_result = BCD_00;
        o_wrap   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_minus1.sv
// Two-digit packed-BCD decrement, 00 rolls to 99.
// Latency: combinational.
// Backpressure: none.
module bcd_minus1 (
  input  logic [7:0] i_bcd,
  output logic [7:0] o_bcd
);

  // Ones digit borrows from the tens digit at 0.
  always_comb begin
    o_bcd = i_bcd;
    if (i_bcd[3:0] == 4'd0) begin
      o_bcd[3:0] = 4'd9;
      o_bcd[7:4] = (i_bcd[7:4] == 4'd0) ? 4'd9 : (i_bcd[7:4] - 4'd1);
    end else begin
      o_bcd[3:0] = i_bcd[3:0] - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_plus1.sv
// Two-digit packed-BCD increment, 99 rolls to 00.
// Latency: combinational.
// Backpressure: none.
module bcd_plus1 (
  input  logic [7:0] i_bcd,
  output logic [7:0] o_bcd
);

  // Ones digit carries into the tens digit at 9.
  always_comb begin
    o_bcd = i_bcd;
    if (i_bcd[3:0] >= 4'd9) begin
      o_bcd[3:0] = 4'd0;
      o_bcd[7:4] = (i_bcd[7:4] >= 4'd9) ? 4'd0 : (i_bcd[7:4] + 4'd1);
    end else begin
      o_bcd[3:0] = i_bcd[3:0] + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_time_sequencer.sv
// BCD hh:mm:ss keeper stepping one field per cycle through shared +1/-1 logic.
// Latency: tick completes in 2/3/4 edges (0/1/2 carries); adjust in 2 edges.
// Backpressure: one pending tick (overflow flagged) and one pending adjust (extras dropped).
module bcd_time_sequencer
  import bcd_clk_pkg::*;
#(
  parameter logic [7:0] HOUR_MAX = 8'h23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       adj_inc,
  input  logic       adj_dec,
  input  logic [1:0] adj_sel,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       busy,
  output logic       hour_wrap,
  output logic       tick_ovr
);

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_sec;
  logic [7:0] r_min;
  logic [7:0] r_hour;

  logic       r_hour_wrap;
  logic       r_tick_ovr;
  logic       r_tick_pend;
  logic       r_adj_pend_vld;
  logic       r_adj_pend_dec;
  logic [1:0] r_adj_pend_sel;
  logic       r_act_dec;
  logic [1:0] r_act_sel;

  logic       w_hour_wrap_nxt;
  logic       w_tick_ovr_nxt;
  logic       w_tick_pend_nxt;
  logic       w_adj_pend_vld_nxt;
  logic       w_adj_pend_dec_nxt;
  logic [1:0] w_adj_pend_sel_nxt;
  logic       w_act_dec_nxt;
  logic [1:0] w_act_sel_nxt;

  logic       w_adj_req;
  logic [7:0] w_operand;
  logic [7:0] w_limit;
  logic       w_dir_dec;
  logic [7:0] w_inc_res;
  logic [7:0] w_dec_res;
  logic [7:0] w_result;
  logic       w_wrap;
  logic       w_wr_sec;
  logic       w_wr_min;
  logic       w_wr_hour;

  assign w_adj_req = adj_req_valid(adj_inc, adj_dec, adj_sel);

  // Single shared incrementer and decrementer; the FSM muxes the operand.
  bcd_plus1 u_plus1 (
    .i_bcd (w_operand),
    .o_bcd (w_inc_res)
  );

  bcd_minus1 u_minus1 (
    .i_bcd (w_operand),
    .o_bcd (w_dec_res)
  );

  bcd_field_limit u_limit (
    .i_operand (w_operand),
    .i_inc_res (w_inc_res),
    .i_dec_res (w_dec_res),
    .i_limit   (w_limit),
    .i_dec     (w_dir_dec),
    .o_result  (w_result),
    .o_wrap    (w_wrap)
  );

  // Next state, pending-request bookkeeping and datapath selection.
  always_comb begin
    w_state_nxt        = r_state;
    w_tick_pend_nxt    = r_tick_pend;
    w_tick_ovr_nxt     = r_tick_ovr;
    w_adj_pend_vld_nxt = r_adj_pend_vld;
    w_adj_pend_dec_nxt = r_adj_pend_dec;
    w_adj_pend_sel_nxt = r_adj_pend_sel;
    w_act_dec_nxt      = r_act_dec;
    w_act_sel_nxt      = r_act_sel;
    w_hour_wrap_nxt    = 1'b0;
    w_operand          = r_sec;
    w_limit            = BCD_59;
    w_dir_dec          = 1'b0;
    w_wr_sec           = 1'b0;
    w_wr_min           = 1'b0;
    w_wr_hour          = 1'b0;

    if (r_state == ST_IDLE) begin
      if (tick || r_tick_pend) begin
        // Ticks win; with both a new and a pending tick, one stays queued.
        w_state_nxt     = ST_SEC;
        w_tick_pend_nxt = tick && r_tick_pend;
        if (w_adj_req && !r_adj_pend_vld) begin
          w_adj_pend_vld_nxt = 1'b1;
          w_adj_pend_dec_nxt = adj_dec;
          w_adj_pend_sel_nxt = adj_sel;
        end
      end else if (r_adj_pend_vld) begin
        // Older adjust goes first; a new one refills the freed slot.
        w_state_nxt        = ST_ADJ;
        w_act_dec_nxt      = r_adj_pend_dec;
        w_act_sel_nxt      = r_adj_pend_sel;
        w_adj_pend_vld_nxt = w_adj_req;
        w_adj_pend_dec_nxt = adj_dec;
        w_adj_pend_sel_nxt = adj_sel;
      end else if (w_adj_req) begin
        w_state_nxt   = ST_ADJ;
        w_act_dec_nxt = adj_dec;
        w_act_sel_nxt = adj_sel;
      end
    end else begin
      // Busy: park requests in the one-deep slots.
      if (tick) begin
        if (r_tick_pend) begin
          w_tick_ovr_nxt = 1'b1;
        end else begin
          w_tick_pend_nxt = 1'b1;
        end
      end
      if (w_adj_req && !r_adj_pend_vld) begin
        w_adj_pend_vld_nxt = 1'b1;
        w_adj_pend_dec_nxt = adj_dec;
        w_adj_pend_sel_nxt = adj_sel;
      end
    end

    case (r_state)
      ST_IDLE: begin
      end
      ST_SEC: begin
        w_operand   = r_sec;
        w_wr_sec    = 1'b1;
        w_state_nxt = w_wrap ? ST_MIN : ST_IDLE;
      end
      ST_MIN: begin
        w_operand   = r_min;
        w_wr_min    = 1'b1;
        w_state_nxt = w_wrap ? ST_HOUR : ST_IDLE;
      end
      ST_HOUR: begin
        w_operand       = r_hour;
        w_limit         = HOUR_MAX;
        w_wr_hour       = 1'b1;
        w_hour_wrap_nxt = w_wrap;
        w_state_nxt     = ST_IDLE;
      end
      ST_ADJ: begin
        // Adjust touches only the latched field; its wrap is not a carry.
        w_dir_dec   = r_act_dec;
        w_state_nxt = ST_IDLE;
        case (r_act_sel)
          SEL_SEC: begin
            w_operand = r_sec;
            w_wr_sec  = 1'b1;
          end
          SEL_MIN: begin
            w_operand = r_min;
            w_wr_min  = 1'b1;
          end
          SEL_HOUR: begin
            w_operand = r_hour;
            w_limit   = HOUR_MAX;
            w_wr_hour = 1'b1;
          end
          default: begin
          end
        endcase
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any carry chain in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Time fields, written one per cycle from the shared result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sec  <= BCD_00;
      r_min  <= BCD_00;
      r_hour <= BCD_00;
    end else begin
      if (w_wr_sec)  r_sec  <= w_result;
      if (w_wr_min)  r_min  <= w_result;
      if (w_wr_hour) r_hour <= w_result;
    end
  end

  // Status flags and the pending tick / adjust slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hour_wrap    <= 1'b0;
      r_tick_ovr     <= 1'b0;
      r_tick_pend    <= 1'b0;
      r_adj_pend_vld <= 1'b0;
      r_adj_pend_dec <= 1'b0;
      r_adj_pend_sel <= SEL_NONE;
      r_act_dec      <= 1'b0;
      r_act_sel      <= SEL_NONE;
    end else begin
      r_hour_wrap    <= w_hour_wrap_nxt;
      r_tick_ovr     <= w_tick_ovr_nxt;
      r_tick_pend    <= w_tick_pend_nxt;
      r_adj_pend_vld <= w_adj_pend_vld_nxt;
      r_adj_pend_dec <= w_adj_pend_dec_nxt;
      r_adj_pend_sel <= w_adj_pend_sel_nxt;
      r_act_dec      <= w_act_dec_nxt;
      r_act_sel      <= w_act_sel_nxt;
    end
  end

  assign sec_bcd   = r_sec;
  assign min_bcd   = r_min;
  assign hour_bcd  = r_hour;
  assign busy      = (r_state != ST_IDLE);
  assign hour_wrap = r_hour_wrap;
  assign tick_ovr  = r_tick_ovr;

endmodule
